// File: rtl/coder_stream_out.sv
// coder_stream_out: snapshots one Kyber coder result bus (pk/sk/c/m) on
// start and streams it out least-significant word first over a
// valid/ready word port with a last-beat marker.
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   start, sel         request a stream of object sel (0 pk,1 sk,2 c,3 m)
//   abort              cancel the transfer in progress
//   pk_in/sk_in/c_in/m_in  coder result buses, sampled only on start
//   tdata/tvalid/tready/tlast  word stream to the host/DMA port
//   busy               high while streaming and during the done cycle
//   done               one-cycle pulse after the final beat is accepted
//
// Build option: define CODER_STREAM_OUT_BYTESWAP_EN to present every word
// byte-reversed on tdata (byte 0 on the top byte lane).
module coder_stream_out #(
    parameter  int unsigned WORD_W = 32,
    localparam int unsigned PK_W   = 6400,
    localparam int unsigned SK_W   = 6144,
    localparam int unsigned C_W    = 6144,
    localparam int unsigned M_W    = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        sel,
    input  logic              abort,
    input  logic [PK_W-1:0]   pk_in,
    input  logic [SK_W-1:0]   sk_in,
    input  logic [C_W-1:0]    c_in,
    input  logic [M_W-1:0]    m_in,
    output logic [WORD_W-1:0] tdata,
    output logic              tvalid,
    input  logic              tready,
    output logic              tlast,
    output logic              busy,
    output logic              done
);

    localparam int unsigned REM_W = 8;
    localparam int unsigned N_PK  = PK_W / WORD_W;
    localparam int unsigned N_SK  = SK_W / WORD_W;
    localparam int unsigned N_C   = C_W / WORD_W;
    localparam int unsigned N_M   = M_W / WORD_W;

    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
        $error("coder_stream_out: WORD_W must be 32 or 64");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state;
    logic [PK_W-1:0]   sreg;
    logic [REM_W-1:0]  rem;
    logic [PK_W-1:0]   snap;
    logic [REM_W-1:0]  rem_init;

    // Selected object, zero-extended to the shift register width.
    always_comb begin
        snap     = '0;
        rem_init = '0;
        case (sel)
            2'd0: begin snap = pk_in;         rem_init = REM_W'(N_PK - 1); end
            2'd1: begin snap = PK_W'(sk_in);  rem_init = REM_W'(N_SK - 1); end
            2'd2: begin snap = PK_W'(c_in);   rem_init = REM_W'(N_C - 1);  end
            default: begin snap = PK_W'(m_in); rem_init = REM_W'(N_M - 1); end
        endcase
    end

    // Control FSM; flags are registered alongside the state they reflect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            sreg   <= '0;
            rem    <= '0;
            tvalid <= 1'b0;
            tlast  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state  <= STREAM;
                        sreg   <= snap;
                        rem    <= rem_init;
                        tvalid <= 1'b1;
                        tlast  <= (rem_init == '0);
                        busy   <= 1'b1;
                    end
                end
                STREAM: begin
                    // Abort wins over a coincident accept; that beat is dropped.
                    if (abort) begin
                        state  <= IDLE;
                        tvalid <= 1'b0;
                        tlast  <= 1'b0;
                        busy   <= 1'b0;
                    end else if (tready) begin
                        sreg <= sreg >> WORD_W;
                        if (rem == '0) begin
                            state  <= DONE;
                            tvalid <= 1'b0;
                            tlast  <= 1'b0;
                            done   <= 1'b1;
                        end else begin
                            rem   <= rem - REM_W'(1);
                            tlast <= (rem == REM_W'(1));
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    tvalid <= 1'b0;
                    tlast  <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                end
            endcase
        end
    end

    // Word presentation straight from the shift register low word.
`ifdef CODER_STREAM_OUT_BYTESWAP_EN
    always_comb begin
        tdata = '0;
        for (int unsigned b = 0; b < WORD_W / 8; b++) begin
            tdata[WORD_W - 1 - 8 * b -: 8] = sreg[8 * b +: 8];
        end
    end
`else
    assign tdata = sreg[WORD_W-1:0];
`endif

endmodule

// File: tb/tb_coder_stream_out.sv
// Testbench for coder_stream_out (WORD_W = 32): table of fixed-pattern
// streams, hand-written corner sequences and randomized streams checked
// against a word-slicing reference model.
module tb_coder_stream_out;

    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    sel = 2'd0;
    logic          abort = 1'b0;
    logic [6399:0] pk_in = '0;
    logic [6143:0] sk_in = '0;
    logic [6143:0] c_in = '0;
    logic [255:0]  m_in = '0;
    logic [W-1:0]  tdata;
    logic          tvalid;
    logic          tready = 1'b0;
    logic          tlast;
    logic          busy;
    logic          done;

    int n_cmp = 0;
    int n_err = 0;

    coder_stream_out #(.WORD_W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .sel(sel), .abort(abort),
        .pk_in(pk_in), .sk_in(sk_in), .c_in(c_in), .m_in(m_in),
        .tdata(tdata), .tvalid(tvalid), .tready(tready), .tlast(tlast),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [31:0] sw(input logic [31:0] x);
`ifdef CODER_STREAM_OUT_BYTESWAP_EN
        return bswap(x);
`else
        return x;
`endif
    endfunction

    function automatic int nbeats(input logic [1:0] s);
        int bits[4] = '{6400, 6144, 6144, 256};
        return bits[s] / W;
    endfunction

    // Object as seen by the sink: zero-extended snapshot of the chosen bus.
    function automatic logic [6399:0] obj_bits(input logic [1:0] s);
        case (s)
            2'd0:    return pk_in;
            2'd1:    return {256'd0, sk_in};
            2'd2:    return {256'd0, c_in};
            default: return {6144'd0, m_in};
        endcase
    endfunction

    function automatic logic [31:0] exp_word(input logic [6399:0] obj, input int i);
        logic [6399:0] s;
        s = obj >> (W * i);
        return sw(s[31:0]);
    endfunction

    task automatic set_fixed();
        for (int i = 0; i < 32; i++) m_in[8*i +: 8] = 8'(i);
        for (int i = 0; i < 32; i++) pk_in[8*i +: 8] = 8'(8'h10 + i);
        for (int j = 0; j < 192; j++) begin
            pk_in[256 + 32*j +: 32] = 32'hB000_0000 | 32'(j);
            sk_in[32*j +: 32]       = 32'hA000_0000 | 32'(j);
            c_in[32*j +: 32]        = 32'hC000_0000 | 32'(j);
        end
    endtask

    task automatic scramble();
        for (int j = 0; j < 200; j++) pk_in[32*j +: 32] = $urandom();
        for (int j = 0; j < 192; j++) begin
            sk_in[32*j +: 32] = $urandom();
            c_in[32*j +: 32]  = $urandom();
        end
        for (int j = 0; j < 8; j++) m_in[32*j +: 32] = $urandom();
    endtask

    // Model-checked stream: every cycle compares the handshake outputs with
    // the word the sink should be seeing next.
    task automatic stream_model(input logic [1:0] s, input int stall_at, input int stall_len,
                                input bit rnd, input int poke_at, input int abort_at,
                                input bit scr, input string nm);
        logic [6399:0] obj;
        int n, i, cyc, stalls, budget;
        bit poked, acc, ab;
        obj = obj_bits(s);
        n = nbeats(s);
        budget = n * 8 + 50;
        i = 0; cyc = 0; stalls = 0; poked = 0; ab = 0;
        sel = s; start = 1'b1; tready = 1'b0;
        step();
        start = 1'b0;
        while (i < n && cyc < budget) begin
            chk({nm, " tvalid"}, 32'(tvalid), 32'd1);
            chk({nm, " tdata"}, tdata, exp_word(obj, i));
            chk({nm, " tlast"}, 32'(tlast), 32'(i == n - 1));
            chk({nm, " busy"}, 32'(busy), 32'd1);
            chk({nm, " done"}, 32'(done), 32'd0);
            start = 1'b0; abort = 1'b0;
            if (scr) scramble();
            if (i == poke_at && !poked) begin start = 1'b1; sel = 2'd3; poked = 1; end
            if (i == abort_at) begin
                abort = 1'b1; tready = 1'b1; ab = 1;
            end else if (i == stall_at && stalls < stall_len) begin
                tready = 1'b0; stalls++;
            end else if (rnd) begin
                tready = ($urandom_range(0, 3) != 0);
            end else begin
                tready = 1'b1;
            end
            acc = tready;
            step();
            start = 1'b0;
            if (ab) begin
                abort = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    chk({nm, " abort tvalid"}, 32'(tvalid), 32'd0);
                    chk({nm, " abort tlast"}, 32'(tlast), 32'd0);
                    chk({nm, " abort busy"}, 32'(busy), 32'd0);
                    chk({nm, " abort done"}, 32'(done), 32'd0);
                    step();
                end
                return;
            end
            if (acc) i++;
            cyc++;
        end
        chk({nm, " beats before timeout"}, 32'(i), 32'(n));
        chk({nm, " done pulse"}, 32'(done), 32'd1);
        chk({nm, " tvalid in done"}, 32'(tvalid), 32'd0);
        chk({nm, " busy in done"}, 32'(busy), 32'd1);
        tready = 1'b0;
        step();
        chk({nm, " done low"}, 32'(done), 32'd0);
        chk({nm, " busy low"}, 32'(busy), 32'd0);
        chk({nm, " idle tvalid"}, 32'(tvalid), 32'd0);
    endtask

    typedef struct {
        logic [1:0]  sel;
        int          beats;
        logic [31:0] first;
        logic [31:0] last;
    } vec_t;

    initial begin
        vec_t vec[4];
        int beats, lasts, last_idx, cyc;
        logic [31:0] got0, gotl;

        vec[0] = '{2'd3, 8,   sw(32'h0302_0100), sw(32'h1F1E_1D1C)};
        vec[1] = '{2'd0, 200, sw(32'h1312_1110), sw(32'hB000_00BF)};
        vec[2] = '{2'd1, 192, sw(32'hA000_0000), sw(32'hA000_00BF)};
        vec[3] = '{2'd2, 192, sw(32'hC000_0000), sw(32'hC000_00BF)};

        set_fixed();
        step();
        chk("reset tvalid", 32'(tvalid), 32'd0);
        chk("reset tdata", tdata, 32'd0);
        chk("reset tlast", 32'(tlast), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        @(negedge clk) rst = 1'b1;
        step();
        step();

        // Fixed-pattern streams with tready held high.
        for (int t = 0; t < 4; t++) begin
            sel = vec[t].sel; start = 1'b1; tready = 1'b1;
            step();
            start = 1'b0;
            chk("tbl first cycle valid", 32'(tvalid), 32'd1);
            beats = 0; lasts = 0; last_idx = -1; cyc = 0; got0 = '0; gotl = '0;
            while (!done && cyc < 400) begin
                if (tvalid) begin
                    if (beats == 0) got0 = tdata;
                    if (tlast) begin lasts++; last_idx = beats; gotl = tdata; end
                    beats++;
                end
                step();
                cyc++;
            end
            chk("tbl beats", 32'(beats), 32'(vec[t].beats));
            chk("tbl done cycle", 32'(cyc), 32'(vec[t].beats));
            chk("tbl tlast count", 32'(lasts), 32'd1);
            chk("tbl tlast index", 32'(last_idx), 32'(vec[t].beats - 1));
            chk("tbl beat0", got0, vec[t].first);
            chk("tbl last word", gotl, vec[t].last);
            step();
            chk("tbl done one cycle", 32'(done), 32'd0);
            chk("tbl busy after done", 32'(busy), 32'd0);
        end

        // pk with a 3-cycle stall at beat 5; beat 8 is t[31:0].
        stream_model(2'd0, 5, 3, 0, -1, -1, 0, "pk stall");
        // Start pulsed mid sk stream must be ignored.
        stream_model(2'd1, -1, 0, 0, 10, -1, 0, "sk ignore start");
        // Abort at beat 50 of c, then a fresh m stream.
        stream_model(2'd2, -1, 0, 0, -1, 50, 0, "c abort");
        stream_model(2'd3, -1, 0, 0, -1, -1, 0, "m after abort");

        // Asynchronous reset in the middle of beat 20 of a pk stream.
        sel = 2'd0; start = 1'b1; tready = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 20; k++) step();
        chk("pre-reset valid", 32'(tvalid), 32'd1);
        #3 rst = 1'b0;
        #1;
        chk("async rst tvalid", 32'(tvalid), 32'd0);
        chk("async rst tdata", tdata, 32'd0);
        chk("async rst tlast", 32'(tlast), 32'd0);
        chk("async rst busy", 32'(busy), 32'd0);
        chk("async rst done", 32'(done), 32'd0);
        @(negedge clk) rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("post rst tvalid", 32'(tvalid), 32'd0);
            chk("post rst done", 32'(done), 32'd0);
        end
        stream_model(2'd3, -1, 0, 0, -1, -1, 0, "m after reset");

        // Randomized objects, selects and backpressure; buses change in flight.
        for (int r = 0; r < 8; r++) begin
            scramble();
            stream_model(2'($urandom_range(0, 3)), -1, 0, 1, -1, -1, 1, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
